// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled at OVERSAMPLE x BAUD with centre sampling.
// Rejects false starts, checks the stop bit and waits out a held-low (break) line.
module uart_rx #(
  parameter int          CLK_HZ     = 12_000_000,
  parameter int          BAUD       = 9600,
  parameter int          OVERSAMPLE = 16,
  parameter logic [15:0] SAMPLE_DIV = 16'(CLK_HZ / (BAUD * OVERSAMPLE))
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int            TW   = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_n;
  logic          rxd_m, rxd_s;
  logic [15:0]   cnt;
  logic          tick;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, err_n;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst)         cnt <= SAMPLE_DIV - 16'd1;
    else if (cnt == 0) cnt <= SAMPLE_DIV - 16'd1;
    else               cnt <= cnt - 16'd1;
  end

  assign tick    = (cnt == 16'd0);
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      tcnt         <= '0;
      bidx         <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_n;
      tcnt         <= tcnt_n;
      bidx         <= bidx_n;
      shreg        <= shreg_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= err_n;
    end
  end

  // Strobes default low every cycle, so they last exactly one clock.
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bidx_n  = bidx;
    shreg_n = shreg;
    data_n  = rx_data;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_n = START;
            tcnt_n  = '0;
          end
        end
        START: begin
          if (tcnt == HALF) begin
            tcnt_n  = '0;
            bidx_n  = '0;
            state_n = rxd_s ? IDLE : DATA;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        DATA: begin
          if (tcnt == LAST) begin
            tcnt_n  = '0;
            shreg_n = {rxd_s, shreg[7:1]};
            bidx_n  = bidx + 3'd1;
            if (bidx == 3'd7) state_n = STOP;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        STOP: begin
          // Returning to IDLE at the stop centre leaves half a bit to catch a back-to-back start.
          if (tcnt == LAST) begin
            tcnt_n  = '0;
            data_n  = shreg;
            valid_n = rxd_s;
            err_n   = !rxd_s;
            state_n = rxd_s ? IDLE : BREAK;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        BREAK: begin
          if (rxd_s) begin
            state_n = IDLE;
            tcnt_n  = '0;
          end
        end
        default: begin
          state_n = IDLE;
          tcnt_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame table plus hand sequences for glitch and mid-frame reset.
// Baud is scaled up so one bit is 16*8 = 128 clk, keeping the run short.
module tb_uart_rx;

  localparam int BIT = 128;

  logic       clk = 1'b0;
  logic       nrst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;

  int checks = 0;
  int errors = 0;

  uart_rx #(.CLK_HZ(12_000_000), .BAUD(93_750), .OVERSAMPLE(16)) dut (
    .clk(clk), .nrst(nrst), .rxd(rxd), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor
  int         n_valid = 0;
  int         n_err = 0;
  logic [7:0] last_data = 8'h00;
  bit         busy_seen = 1'b0;
  bit         prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (rx_busy) busy_seen = 1'b1;
    if (rx_valid) begin
      n_valid++;
      last_data = rx_data;
    end
    if (rx_frame_err) n_err++;
    if (rx_valid || rx_frame_err) begin
      checks++;
      if ((rx_valid && rx_frame_err) || prev_strobe) begin
        errors++;
        $display("FAIL strobe_shape: valid=%0b err=%0b prev=%0b, required single exclusive pulse",
                 rx_valid, rx_frame_err, prev_strobe);
      end
    end
    prev_strobe = rx_valid || rx_frame_err;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int per);
    line(1'b0, per);
    for (int i = 0; i < 8; i++) line(d[i], per);
    line(stop, per);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         per;
    int         hold;   // extra bit times held low after the stop bit
    int         gap;    // idle bit times after the frame
    int         exp_v;
    int         exp_e;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send(v.data, v.stop, v.per);
    if (v.hold > 0) line(1'b0, v.hold * v.per);
    rxd = 1'b1;
    repeat (v.gap * v.per) @(posedge clk);
    chk($sformatf("valid_count[%0h]", v.data), n_valid - v0, v.exp_v);
    chk($sformatf("err_count[%0h]", v.data), n_err - e0, v.exp_e);
    if (v.exp_v + v.exp_e > 0) chk($sformatf("rx_data[%0h]", v.data), int'(rx_data), int'(v.data));
    if (v.exp_v > 0) chk($sformatf("strobe_data[%0h]", v.data), int'(last_data), int'(v.data));
    if (v.gap > 0) begin
      @(negedge clk);
      chk($sformatf("busy_after[%0h]", v.data), int'(rx_busy), 0);
    end
  endtask

  vec_t tbl[8];

  initial begin
    int v0, e0;
    vec_t r;
    tbl[0] = '{8'h55, 1'b1, BIT,     0, 2, 1, 0};
    tbl[1] = '{8'hA5, 1'b1, BIT,     0, 0, 1, 0};
    tbl[2] = '{8'h3C, 1'b1, BIT,     0, 2, 1, 0};
    tbl[3] = '{8'h00, 1'b1, BIT,     0, 2, 1, 0};
    tbl[4] = '{8'hFF, 1'b0, BIT,     5, 2, 0, 1};
    tbl[5] = '{8'h12, 1'b1, BIT,     0, 2, 1, 0};
    tbl[6] = '{8'hC3, 1'b1, 132,     0, 2, 1, 0};
    tbl[7] = '{8'hC3, 1'b1, 124,     0, 2, 1, 0};

    rxd  = 1'b1;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_frame_err", int'(rx_frame_err), 0);
    chk("reset_rx_busy", int'(rx_busy), 0);
    nrst = 1'b1;
    repeat (BIT) @(posedge clk);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Mid-frame reset after four data bits of 0x81
    v0 = n_valid;
    e0 = n_err;
    line(1'b0, BIT);
    line(1'b1, BIT);
    line(1'b0, BIT);
    line(1'b0, BIT);
    line(1'b0, BIT);
    @(negedge clk);
    chk("busy_mid_frame", int'(rx_busy), 1);
    nrst = 1'b0;
    rxd  = 1'b1;
    @(negedge clk);
    chk("abort_rx_data", int'(rx_data), 0);
    chk("abort_rx_valid", int'(rx_valid), 0);
    chk("abort_rx_frame_err", int'(rx_frame_err), 0);
    chk("abort_rx_busy", int'(rx_busy), 0);
    nrst = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    chk("abort_valid_count", n_valid - v0, 0);
    chk("abort_err_count", n_err - e0, 0);
    r = '{8'h81, 1'b1, BIT, 0, 2, 1, 0};
    run_vec(r);

    // Short low glitch: start is detected, then rejected at the half-bit check
    v0 = n_valid;
    e0 = n_err;
    busy_seen = 1'b0;
    line(1'b0, 30);
    line(1'b1, 2 * BIT);
    @(negedge clk);
    chk("glitch_busy_seen", int'(busy_seen), 1);
    chk("glitch_busy_end", int'(rx_busy), 0);
    chk("glitch_valid_count", n_valid - v0, 0);
    chk("glitch_err_count", n_err - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
